ivl_uvm_ovl_no_overflow_mc: RTL

- Multi-channel, parametrised successor to the single-bit OVL no_overflow checker.
- Monitors CHANNELS independent WIDTH-bit expressions packed on one bus.
- Flags any channel that leaves MAX for a value outside (MIN, MAX].
- Adds sticky/pulse fire modes, a saturating violation counter and a MAX-hit coverage counter for the ivl_uvm OVL test benches.

---
 rtl/ivl_uvm_ovl_no_overflow_mc.sv | 117 +++++++++++
 1 files changed

// File: rtl/ivl_uvm_ovl_no_overflow_mc.sv
// Multi-channel no-overflow checker.
// Each WIDTH-bit channel of test_expr is watched for leaving MAX towards a
// value outside (MIN, MAX]. Violations raise a registered per-channel fire
// bit (sticky or pulsed), bump a saturating error counter, and entries into
// MAX bump a saturating coverage counter. All state updates on posedge clock
// with a synchronous active-low reset that dominates every other input.
module ivl_uvm_ovl_no_overflow_mc #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int MIN       = 0,
    parameter int MAX       = 255,
    parameter int CNT_WIDTH = 8,
    parameter int STICKY    = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS*WIDTH-1:0] test_expr,
    input  logic                      fire_clear,
    output logic [CHANNELS-1:0]       fire,
    output logic                      fire_any,
    output logic [CNT_WIDTH-1:0]      err_count,
    output logic [CNT_WIDTH-1:0]      cov_count
);

    // Bounds carried one bit wider than a channel so the "above MAX" test
    // stays a real comparison even when MAX is the all-ones value.
    localparam logic [WIDTH:0]       MIN_X = MIN[WIDTH:0];
    localparam logic [WIDTH:0]       MAX_X = MAX[WIDTH:0];
    localparam logic [CNT_WIDTH-1:0] SAT_V = '1;

    // Illegal parameter sets stop elaboration.
    if (CHANNELS < 1 || MIN >= MAX ||
        longint'(MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_param_err
        $error("ivl_uvm_ovl_no_overflow_mc: illegal parameters (need CHANNELS>=1, MIN<MAX<=2**WIDTH-1)");
    end

    logic [CHANNELS-1:0]  at_max_q, at_max_d;
    logic [CHANNELS-1:0]  fire_q, fire_d;
    logic                 fire_any_q, fire_any_d;
    logic [CNT_WIDTH-1:0] err_q, err_d;
    logic [CNT_WIDTH-1:0] cov_q, cov_d;

    logic [WIDTH:0]       expr_x [CHANNELS];
    logic [CHANNELS-1:0]  is_max;
    logic [CHANNELS-1:0]  viol;
    logic [CHANNELS-1:0]  rise;
    int unsigned          viol_n;
    int unsigned          rise_n;

    // Add n to a counter, clamping at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] c,
        input int unsigned          n
    );
        logic [CNT_WIDTH-1:0] room;
        room = SAT_V - c;
        if (n >= 32'(room)) begin
            return SAT_V;
        end
        return c + n[CNT_WIDTH-1:0];
    endfunction

    // Per-channel classification: at MAX, violating exit, rising into MAX.
    always_comb begin
        is_max = '0;
        viol   = '0;
        rise   = '0;
        viol_n = 0;
        rise_n = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            expr_x[i] = {1'b0, test_expr[i*WIDTH +: WIDTH]};
            is_max[i] = (expr_x[i] == MAX_X);
            viol[i]   = enable & at_max_q[i] &
                        ((expr_x[i] <= MIN_X) | (expr_x[i] > MAX_X));
            rise[i]   = enable & is_max[i] & ~at_max_q[i];
            viol_n    = viol_n + 32'(viol[i]);
            rise_n    = rise_n + 32'(rise[i]);
        end
    end

    // Next-state: history breaks on a disabled cycle; a new violation beats fire_clear.
    always_comb begin
        at_max_d = enable ? is_max : '0;
        if (STICKY != 0) begin
            fire_d = viol | (fire_q & ~{CHANNELS{fire_clear}});
        end else begin
            fire_d = viol;
        end
        fire_any_d = |fire_d;
        err_d      = sat_add(err_q, viol_n);
        cov_d      = sat_add(cov_q, rise_n);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            at_max_q   <= '0;
            fire_q     <= '0;
            fire_any_q <= 1'b0;
            err_q      <= '0;
            cov_q      <= '0;
        end else begin
            at_max_q   <= at_max_d;
            fire_q     <= fire_d;
            fire_any_q <= fire_any_d;
            err_q      <= err_d;
            cov_q      <= cov_d;
        end
    end

    assign fire      = fire_q;
    assign fire_any  = fire_any_q;
    assign err_count = err_q;
    assign cov_count = cov_q;

endmodule
